// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (ALU_MUL .. ALU_NOT); 12..15 are reserved
//   - FSM state type
//   - bit positions of the packed flag vector (zero, sign, carry/borrow)
package alu_seq_pkg;

    localparam logic [3:0] ALU_MUL  = 4'd0;
    localparam logic [3:0] ALU_SHL  = 4'd1;
    localparam logic [3:0] ALU_SHR  = 4'd2;
    localparam logic [3:0] ALU_ROL  = 4'd3;
    localparam logic [3:0] ALU_ROR  = 4'd4;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_NAND = 4'd8;
    localparam logic [3:0] ALU_OR   = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_NOT  = 4'd11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_S = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_W = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative unsigned shift-add multiplier, one partial-product add per cycle.
//   Clock, Resetn : clock, asynchronous active-low reset
//   start         : load a/b and begin a WIDTH-cycle multiply
//   a, b          : operands (sampled on start)
//   done          : high during the final iteration cycle
//   product       : full 2*WIDTH product, valid while done is high
module alu_seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [CntW-1:0]    cnt_q;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // The last add is presented combinationally so the caller can register
    // the product on the same edge that ends the multiply.
    assign product = acc_next;
    assign done    = (cnt_q == CntW'(1));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CntW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake on both sides.
//   Clock, Resetn          : clock, asynchronous active-low reset
//   InValid / InReady      : request handshake; Inst, A, BusWires used on accept
//   OutValid / OutReady    : result handshake; Result and flags hold until taken
//   Result                 : 2*WIDTH registered result
//   Zout, Sout, Cout       : zero, sign, carry/borrow flags
//   Busy                   : multiply in progress
// Build option: define ALU_SEQ_MUL_EN to include the iterative multiplier;
// otherwise Multiply behaves as a reserved opcode and Busy is tied low.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [3:0]           Inst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     BusWires,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 Zout,
    output logic                 Sout,
    output logic                 Cout,
    output logic                 Busy
);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;

    logic               accept;
    logic               is_mul;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] op_res;
    logic               op_c;
    logic [FLAG_W-1:0]  op_flags;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [FLAG_W-1:0]  mul_flags;

    assign InReady = (state_q == StIdle) || ((state_q == StDone) && OutReady);
    assign accept  = InValid && InReady;

`ifdef ALU_SEQ_MUL_EN
    assign is_mul = (Inst == ALU_MUL);
    assign Busy   = (state_q == StMul);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .start   (accept && is_mul),
        .a       (A),
        .b       (BusWires),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    // Multiply falls through to the reserved-opcode path below.
    assign is_mul      = 1'b0;
    assign Busy        = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // Single-cycle operations, evaluated on the operands presented at accept.
    always_comb begin
        sum    = {1'b0, A} + {1'b0, BusWires};
        op_res = '0;
        op_c   = 1'b0;
        case (Inst)
            ALU_SHL: begin
                op_res = {{WIDTH{1'b0}}, A << 1};
                op_c   = A[WIDTH-1];
            end
            ALU_SHR: begin
                op_res = {{WIDTH{1'b0}}, A >> 1};
                op_c   = A[0];
            end
            ALU_ROL: begin
                op_res = {{WIDTH{1'b0}}, A[WIDTH-2:0], A[WIDTH-1]};
                op_c   = A[WIDTH-1];
            end
            ALU_ROR: begin
                op_res = {{WIDTH{1'b0}}, A[0], A[WIDTH-1:1]};
                op_c   = A[0];
            end
            ALU_ADD: begin
                op_res = {{(WIDTH-1){1'b0}}, sum};
                op_c   = sum[WIDTH];
            end
            ALU_SUB: begin
                // Zero-extended difference: a borrow sign-fills the upper half.
                op_res = {{WIDTH{1'b0}}, A} - {{WIDTH{1'b0}}, BusWires};
                op_c   = (A < BusWires);
            end
            ALU_AND:  op_res = {{WIDTH{1'b0}}, A & BusWires};
            ALU_NAND: op_res = {{WIDTH{1'b0}}, ~(A & BusWires)};
            ALU_OR:   op_res = {{WIDTH{1'b0}}, A | BusWires};
            ALU_NOR:  op_res = {{WIDTH{1'b0}}, ~(A | BusWires)};
            ALU_NOT:  op_res = {{WIDTH{1'b0}}, ~A};
            default: ;  // multiply without the multiplier, and reserved opcodes
        endcase
    end

    always_comb begin
        op_flags         = '0;
        op_flags[FLAG_Z] = (op_res == '0);
        op_flags[FLAG_S] = (Inst == ALU_SUB) ? op_res[2*WIDTH-1] : op_res[WIDTH-1];
        op_flags[FLAG_C] = op_c;

        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_product == '0);
        mul_flags[FLAG_S] = mul_product[2*WIDTH-1];
        mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (accept) begin
            if (is_mul) begin
                state_d = StMul;
            end else begin
                state_d  = StDone;
                result_d = op_res;
                flags_d  = op_flags;
            end
        end else begin
            case (state_q)
                StMul: begin
                    if (mul_done) begin
                        state_d  = StDone;
                        result_d = mul_product;
                        flags_d  = mul_flags;
                    end
                end
                StDone: begin
                    if (OutReady) begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= StIdle;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign OutValid = (state_q == StDone);
    assign Result   = result_q;
    assign Zout     = flags_q[FLAG_Z];
    assign Sout     = flags_q[FLAG_S];
    assign Cout     = flags_q[FLAG_C];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// Works with or without ALU_SEQ_MUL_EN defined.
module tb_alu_seq;

    localparam int unsigned WIDTH = 8;

    logic             Clock;
    logic             Resetn;
    logic             InValid;
    logic             InReady;
    logic [3:0]       Inst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] BusWires;
    logic             OutValid;
    logic             OutReady;
    logic [15:0]      Result;
    logic             Zout;
    logic             Sout;
    logic             Cout;
    logic             Busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .InValid  (InValid),
        .InReady  (InReady),
        .Inst     (Inst),
        .A        (A),
        .BusWires (BusWires),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .Zout     (Zout),
        .Sout     (Sout),
        .Cout     (Cout),
        .Busy     (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic rdy);
        InValid  = v;
        Inst     = op;
        A        = a;
        BusWires = b;
        OutReady = rdy;
    endtask

    task automatic check_out(input string tag, input logic [15:0] res, input logic z,
                             input logic s, input logic c);
        check_eq({tag, ".valid"}, {31'd0, OutValid}, 32'd1);
        check_eq({tag, ".result"}, {16'd0, Result}, {16'd0, res});
        check_eq({tag, ".zsc"}, {29'd0, Zout, Sout, Cout}, {29'd0, z, s, c});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".result"}, {16'd0, Result}, 32'd0);
        check_eq({tag, ".zsc_valid_busy"}, {27'd0, Zout, Sout, Cout, OutValid, Busy}, 32'd0);
    endtask

    initial begin
        int busy_cycles;

        Resetn = 1'b0;
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        #3;
        check_reset_outputs("reset");
        step();
        step();
        Resetn = 1'b1;
        check_eq("reset.inready", {31'd0, InReady}, 32'd1);

        // Add with carry out.
        drive(1'b1, 4'd5, 8'hFF, 8'h01, 1'b0);
        step();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        check_out("add_ff_01", 16'h0100, 1'b0, 1'b0, 1'b1);

        // Sub with borrow, accepted in DONE while the add result is taken.
        drive(1'b1, 4'd6, 8'h10, 8'h20, 1'b1);
        step();
        check_out("sub_borrow", 16'hFFF0, 1'b0, 1'b1, 1'b1);

        drive(1'b1, 4'd6, 8'h20, 8'h20, 1'b1);
        step();
        check_out("sub_zero", 16'h0000, 1'b1, 1'b0, 1'b0);

        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        step();
        check_eq("drain.valid", {31'd0, OutValid}, 32'd0);

`ifdef ALU_SEQ_MUL_EN
        // Iterative multiply: busy for WIDTH cycles, result at accept+WIDTH+1.
        drive(1'b1, 4'd0, 8'hFF, 8'hFF, 1'b0);
        step();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        busy_cycles = 0;
        while (Busy && busy_cycles < 20) begin
            busy_cycles++;
            step();
        end
        check_eq("mul.busy_cycles", busy_cycles, 32'd8);
        check_out("mul_ff_ff", 16'hFE01, 1'b0, 1'b1, 1'b1);
`else
        // Multiply without the multiplier behaves like a reserved opcode.
        drive(1'b1, 4'd0, 8'h03, 8'h04, 1'b0);
        step();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        check_eq("mul_off.busy", {31'd0, Busy}, 32'd0);
        check_out("mul_off", 16'h0000, 1'b1, 1'b0, 1'b0);
`endif

        // Reserved opcode.
        drive(1'b1, 4'hF, 8'h03, 8'h04, 1'b1);
        step();
        check_out("reserved_f", 16'h0000, 1'b1, 1'b0, 1'b0);
        check_eq("reserved_f.busy", {31'd0, Busy}, 32'd0);

        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        step();

        // Back-pressure: Rol held while a competing request is presented.
        drive(1'b1, 4'd3, 8'h81, 8'h00, 1'b0);
        step();
        drive(1'b1, 4'd5, 8'h01, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_out("rol_hold", 16'h0003, 1'b0, 1'b0, 1'b1);
            check_eq("rol_hold.inready", {31'd0, InReady}, 32'd0);
            step();
        end
        check_out("rol_held", 16'h0003, 1'b0, 1'b0, 1'b1);

        // Release with a Nand queued: accepted in the same cycle.
        drive(1'b1, 4'd8, 8'hF0, 8'hFF, 1'b1);
        #1;
        check_eq("nand.inready", {31'd0, InReady}, 32'd1);
        step();
        check_out("nand_f0_ff", 16'h000F, 1'b0, 1'b0, 1'b0);

        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        step();

`ifdef ALU_SEQ_MUL_EN
        // Reset in the fourth multiply cycle.
        drive(1'b1, 4'd0, 8'h05, 8'h07, 1'b0);
        step();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        step();
        step();
        step();
        check_eq("mul_abort.busy_before", {31'd0, Busy}, 32'd1);
`else
        drive(1'b1, 4'd7, 8'hFF, 8'h0F, 1'b0);
        step();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
`endif
        Resetn = 1'b0;
        #1;
        check_reset_outputs("abort");
        step();
        Resetn = 1'b1;
        check_eq("abort.inready", {31'd0, InReady}, 32'd1);

        drive(1'b1, 4'd5, 8'h02, 8'h03, 1'b1);
        step();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
        check_out("add_after_abort", 16'h0005, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("final.valid", {31'd0, OutValid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
